// File: rtl/timer_pkg.sv
// Shared timer definitions: edge-select encoding, capture FIFO depth, edge decode helpers.
// No latency: types, constants and pure functions only.
// No flow control.
package timer_pkg;

   typedef enum logic [1:0] {
      EDGE_NONE = 2'b00,
      EDGE_RISE = 2'b01,
      EDGE_FALL = 2'b10,
      EDGE_BOTH = 2'b11
   } edge_sel_t;

   localparam int CAP_FIFO_DEPTH = 2;

   // True when the selection qualifies rising edges of the measured input.
   function automatic logic takes_rise(edge_sel_t s);
      return (s == EDGE_RISE) || (s == EDGE_BOTH);
   endfunction

   // True when the selection qualifies falling edges of the measured input.
   function automatic logic takes_fall(edge_sel_t s);
      return (s == EDGE_FALL) || (s == EDGE_BOTH);
   endfunction

endpackage

// File: rtl/cap_fifo2.sv
// Two-entry FIFO for captured intervals; head is always entry 0 and reads 0 when empty.
// Latency: a push into an empty FIFO is visible at head one cycle later.
// Backpressure: pop on empty is ignored; push on full is dropped unless popped in the same cycle.
module cap_fifo2
   import timer_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);

   localparam logic [1:0] FULL_CNT = 2'(CAP_FIFO_DEPTH);

   logic [W-1:0] e0;
   logic [W-1:0] e1;
   logic [1:0]   cnt;

   // Entry storage and occupancy; unoccupied slots are kept at zero so head reads 0 when empty.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e0  <= '0;
         e1  <= '0;
         cnt <= '0;
      end else begin
         case (cnt)
            2'd0: begin
               // Nothing to pop yet, so a concurrent pop is ignored.
               if (push) begin
                  e0  <= din;
                  cnt <= 2'd1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  e0 <= din;
               end else if (push) begin
                  e1  <= din;
                  cnt <= 2'd2;
               end else if (pop) begin
                  e0  <= '0;
                  cnt <= 2'd0;
               end
            end
            default: begin
               // Full: a push only lands when the head leaves in the same cycle.
               if (pop) begin
                  e0 <= e1;
                  if (push) begin
                     e1 <= din;
                  end else begin
                     e1  <= '0;
                     cnt <= 2'd1;
                  end
               end
            end
         endcase
      end
   end

   assign head  = e0;
   assign full  = (cnt == FULL_CNT);
   assign empty = (cnt == 2'd0);

endmodule

// File: rtl/timer_capture.sv
// Input capture: measures clk cycles between qualifying edges of async cap_in into a 2-entry FIFO.
// Latency: 3 rising edges from a cap_in change to the captured value appearing at cap_value.
// Backpressure: reader pops with rd_ack; a capture arriving while full is dropped and sets sticky overrun.
module timer_capture
   import timer_pkg::*;
#(
   parameter int BITS = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic [1:0]      edge_sel,
   input  logic            cap_in,
   input  logic            rd_ack,
   input  logic            ovr_clr,
   output logic            cap_valid,
   output logic [BITS-1:0] cap_value,
   output logic            overrun
);

   localparam logic [BITS-1:0] SAT = '1;

   logic            s1;
   logic            s2;
   logic            s3;
   logic [BITS-1:0] elapsed;
   logic            armed;
   edge_sel_t       sel;
   logic            rise;
   logic            fall;
   logic            qe;
   logic            push;
   logic            drop;
   logic            fifo_full;
   logic            fifo_empty;
   logic [BITS-1:0] fifo_head;

   assign sel  = edge_sel_t'(edge_sel);
   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;
   assign qe   = enable & ((rise & takes_rise(sel)) | (fall & takes_fall(sel)));
   assign push = qe & armed;
   // When full the FIFO is non-empty, so rd_ack is always an accepted pop here.
   assign drop = push & fifo_full & ~rd_ack;

   // Two-flop synchroniser plus a third flop holding the previous synchronised level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= cap_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Interval counter restarts at 1 on each qualifying edge, saturates instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         elapsed <= '0;
         armed   <= 1'b0;
      end else if (!enable) begin
         elapsed <= '0;
         armed   <= 1'b0;
      end else if (qe) begin
         elapsed <= BITS'(1);
         armed   <= 1'b1;
      end else if (elapsed != SAT) begin
         elapsed <= elapsed + 1'b1;
      end
   end

   // Sticky overrun; a new drop outranks a clear in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (ovr_clr) begin
         overrun <= 1'b0;
      end
   end

   cap_fifo2 #(
      .W(BITS)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (rd_ack),
      .din   (elapsed),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign cap_valid = ~fifo_empty;
   assign cap_value = fifo_head;

endmodule

// File: tb/tb_timer_capture.sv
module tb_timer_capture;

   localparam int BITS = 4;
   localparam int SATV = 15;

   logic            clk = 1'b0;
   logic            rst;
   logic            enable;
   logic [1:0]      edge_sel;
   logic            cap_in;
   logic            rd_ack;
   logic            ovr_clr;
   logic            cap_valid;
   logic [BITS-1:0] cap_value;
   logic            overrun;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   timer_capture #(.BITS(BITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .edge_sel  (edge_sel),
      .cap_in    (cap_in),
      .rd_ack    (rd_ack),
      .ovr_clr   (ovr_clr),
      .cap_valid (cap_valid),
      .cap_value (cap_value),
      .overrun   (overrun)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic hold(input logic v, input int n);
      cap_in = v;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; cap_in = 1'b0; rd_ack = 1'b0; ovr_clr = 1'b0; enable = 1'b1;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic pop1();
      rd_ack = 1'b1; tick(); rd_ack = 1'b0;
   endtask

   // Reference model: intervals from timestamps of qualifying cap_in changes,
   // delivered 3 edges after the change, into a bounded queue.
   int  mq[$];
   int  sched_cyc[$];
   int  sched_val[$];
   bit  m_ovr;
   bit  m_armed;
   int  m_last;

   task automatic model_reset();
      mq.delete(); sched_cyc.delete(); sched_val.delete();
      m_ovr = 0; m_armed = 0; m_last = 0;
   endtask

   task automatic model_edge();
      bit do_push = 0;
      int pv = 0;
      int junk;
      bit pop_eff, drop;
      if (sched_cyc.size() > 0 && sched_cyc[0] == cyc) begin
         do_push = 1;
         pv = sched_val.pop_front();
         junk = sched_cyc.pop_front();
      end
      pop_eff = rd_ack && (mq.size() > 0);
      drop = do_push && (mq.size() == 2) && !pop_eff;
      if (pop_eff) junk = mq.pop_front();
      if (do_push && !drop) mq.push_back(pv);
      if (drop) m_ovr = 1;
      else if (ovr_clr) m_ovr = 0;
   endtask

   task automatic model_input(input logic prev, input logic now);
      int d;
      if (prev != now && ((now && edge_sel[0]) || (!now && edge_sel[1]))) begin
         if (m_armed) begin
            d = cyc - m_last;
            sched_cyc.push_back(cyc + 3);
            sched_val.push_back(d > SATV ? SATV : d);
         end
         m_last  = cyc;
         m_armed = 1;
      end
   endtask

   typedef struct {
      logic [1:0] sel;
      int         hi;
      int         lo;
      int         periods;
      int         cnt;
      int         v0;
      int         v1;
      int         ovr;
   } vec_t;

   vec_t tbl[7];
   logic nv;

   initial begin
      rst = 1'b1; enable = 1'b1; edge_sel = 2'b01; cap_in = 1'b0; rd_ack = 1'b0; ovr_clr = 1'b0;

      tbl[0] = '{2'b01,  3,  3, 3, 2,  6,  6, 0};
      tbl[1] = '{2'b01,  3,  3, 4, 2,  6,  6, 1};
      tbl[2] = '{2'b11,  3,  5, 2, 2,  3,  5, 1};
      tbl[3] = '{2'b01, 20, 20, 3, 2, 15, 15, 0};
      tbl[4] = '{2'b10,  2,  5, 3, 2,  7,  7, 0};
      tbl[5] = '{2'b00,  3,  3, 3, 0,  0,  0, 0};
      tbl[6] = '{2'b01,  1,  1, 2, 1,  2,  0, 0};

      // Reset and idle.
      edge_sel = 2'b01;
      do_reset();
      hold(1'b0, 20);
      chk("idle_valid", cap_valid, 0);
      chk("idle_value", cap_value, 0);
      chk("idle_overrun", overrun, 0);

      // Waveform table: run the wave without reading, then drain and compare.
      foreach (tbl[k]) begin
         edge_sel = tbl[k].sel;
         do_reset();
         hold(1'b0, 3);
         for (int p = 0; p < tbl[k].periods; p++) begin
            hold(1'b1, tbl[k].hi);
            hold(1'b0, tbl[k].lo);
         end
         hold(1'b0, 5);
         chk($sformatf("tbl%0d_valid0", k), cap_valid, tbl[k].cnt > 0);
         chk($sformatf("tbl%0d_value0", k), cap_value, tbl[k].cnt > 0 ? tbl[k].v0 : 0);
         chk($sformatf("tbl%0d_overrun", k), overrun, tbl[k].ovr);
         pop1();
         chk($sformatf("tbl%0d_valid1", k), cap_valid, tbl[k].cnt > 1);
         chk($sformatf("tbl%0d_value1", k), cap_value, tbl[k].cnt > 1 ? tbl[k].v1 : 0);
         pop1();
         chk($sformatf("tbl%0d_empty", k), cap_valid, 0);
      end

      // Latency: captured value appears exactly 3 edges after the measured rise.
      edge_sel = 2'b01;
      do_reset();
      hold(1'b0, 3);
      hold(1'b1, 3); hold(1'b0, 3);
      cap_in = 1'b1; tick(); tick();
      chk("lat_valid_e2", cap_valid, 0);
      tick();
      chk("lat_valid_e3", cap_valid, 1);
      chk("lat_value_e3", cap_value, 6);
      pop1();
      chk("lat_pop_valid", cap_valid, 0);
      chk("lat_pop_value", cap_value, 0);

      // Full FIFO with pop on the push cycle, then drop with simultaneous clear.
      do_reset();
      hold(1'b0, 3);
      hold(1'b1, 2); hold(1'b0, 3);
      hold(1'b1, 3); hold(1'b0, 4);
      hold(1'b1, 4); hold(1'b0, 4);
      cap_in = 1'b1; tick(); tick();
      chk("full_pre_head", cap_value, 5);
      rd_ack = 1'b1; tick(); rd_ack = 1'b0;
      chk("full_pop_push_head", cap_value, 7);
      chk("full_pop_push_ovr", overrun, 0);
      cap_in = 1'b0; tick(); tick(); tick();
      cap_in = 1'b1; tick(); tick();
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      chk("set_beats_clear", overrun, 1);
      chk("drop_keeps_head", cap_value, 7);
      ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
      chk("ovr_clr", overrun, 0);
      pop1();
      chk("full_second", cap_value, 8);
      pop1();
      chk("full_drained", cap_valid, 0);

      // Asynchronous reset mid-measurement.
      do_reset();
      hold(1'b0, 2);
      hold(1'b1, 3); hold(1'b0, 3);
      cap_in = 1'b1; repeat (3) tick();
      chk("mid_pre_valid", cap_valid, 1);
      chk("mid_pre_value", cap_value, 6);
      repeat (3) tick();
      #2 rst = 1'b1; cap_in = 1'b0;
      #1;
      chk("mid_rst_valid", cap_valid, 0);
      chk("mid_rst_value", cap_value, 0);
      #2 rst = 1'b0;
      hold(1'b0, 2);
      hold(1'b1, 3); hold(1'b0, 3);
      cap_in = 1'b1; tick(); tick();
      chk("mid_arm_only", cap_valid, 0);
      tick();
      chk("mid_post_valid", cap_valid, 1);
      chk("mid_post_value", cap_value, 6);
      pop1();

      // Disable/enable clears arming: first rise after re-enable only arms.
      enable = 1'b0; repeat (3) tick(); enable = 1'b1;
      hold(1'b0, 2);
      hold(1'b1, 3); hold(1'b0, 3);
      cap_in = 1'b1; repeat (3) tick();
      chk("reen_value", cap_value, 6);
      pop1();
      chk("reen_single", cap_valid, 0);

      // Randomised traffic against the reference model, every edge selection.
      for (int s = 0; s < 4; s++) begin
         edge_sel = 2'(s);
         do_reset();
         model_reset();
         for (int i = 0; i < 400; i++) begin
            tick();
            model_edge();
            chk("rnd_valid", cap_valid, mq.size() > 0);
            chk("rnd_value", cap_value, mq.size() > 0 ? mq[0] : 0);
            chk("rnd_overrun", overrun, m_ovr);
            nv = ($urandom_range(0, 5) == 0) ? ~cap_in : cap_in;
            model_input(cap_in, nv);
            cap_in  = nv;
            rd_ack  = ($urandom_range(0, 3) == 0);
            ovr_clr = ($urandom_range(0, 11) == 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
